// File: rtl/sh2_regfile_mp.sv
// SH-2 style register file: immediate write port A, one-cycle deferred port B, NRD read ports.
// Optional DBG_REGS port exposing committed contents is enabled by defining SH_REGFILE_DBG_EN.
module sh2_regfile_mp #(
  parameter int DW   = 32,
  parameter int NREG = 17,
  parameter int NRD  = 2,
  parameter int AW   = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CE,
  input  logic                EN,
  input  logic [AW-1:0]       WA_ADDR,
  input  logic [DW-1:0]       WA_D,
  input  logic                WAE,
  input  logic [AW-1:0]       WB_ADDR,
  input  logic [DW-1:0]       WB_D,
  input  logic                WBE,
  input  logic [NRD*AW-1:0]   RD_ADDR,
  output logic [NRD*DW-1:0]   RD_Q,
  output logic [DW-1:0]       R0_Q,
  output logic                WB_PEND
`ifdef SH_REGFILE_DBG_EN
  ,output logic [NREG*DW-1:0] DBG_REGS
`endif
);

  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_d;
  logic          lb_valid;
  logic          a_commit;
  logic          b_commit;

  assign a_commit = WAE & CE & EN;
  assign b_commit = lb_valid & EN;
  assign WB_PEND  = lb_valid;

  // Per-register decode drops out-of-range addresses; port B wins a same-address collision.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      R0_Q     <= '0;
      lb_addr  <= '0;
      lb_d     <= '0;
      lb_valid <= 1'b0;
    end else begin
      if (CE) begin
        lb_addr  <= WB_ADDR;
        lb_d     <= WB_D;
        lb_valid <= WBE;
      end else begin
        lb_valid <= 1'b0;
      end
      for (int i = 0; i < NREG; i++) begin
        if (b_commit && lb_addr == AW'(i))
          regs[i] <= lb_d;
        else if (a_commit && WA_ADDR == AW'(i))
          regs[i] <= WA_D;
      end
      if (b_commit && lb_addr == '0)
        R0_Q <= lb_d;
      else if (a_commit && WA_ADDR == '0)
        R0_Q <= WA_D;
    end
  end

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(NREG);
  endfunction

  // Only the latched port-B value is forwarded; in-flight port-A data is not.
  function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] a);
    logic [DW-1:0] q;
    q = '0;
    if (in_range(a)) begin
      if (lb_valid && lb_addr == a) begin
        q = lb_d;
      end else begin
        for (int i = 0; i < NREG; i++)
          if (a == AW'(i)) q = regs[i];
      end
    end
    return q;
  endfunction

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign RD_Q[p*DW +: DW] = read_reg(RD_ADDR[p*AW +: AW]);
  end

`ifdef SH_REGFILE_DBG_EN
  for (genvar r = 0; r < NREG; r++) begin : g_dbg
    assign DBG_REGS[r*DW +: DW] = regs[r];
  end
`endif

endmodule

// File: tb/tb_sh2_regfile_mp.sv
// Directed self-checking bench for sh2_regfile_mp, built with four read ports.
`timescale 1ns/10ps
module tb_sh2_regfile_mp;

  localparam int DW   = 32;
  localparam int NREG = 17;
  localparam int NRD  = 4;
  localparam int AW   = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              CE = 1'b0;
  logic              EN = 1'b0;
  logic [AW-1:0]     WA_ADDR = '0;
  logic [DW-1:0]     WA_D = '0;
  logic              WAE = 1'b0;
  logic [AW-1:0]     WB_ADDR = '0;
  logic [DW-1:0]     WB_D = '0;
  logic              WBE = 1'b0;
  logic [NRD*AW-1:0] RD_ADDR = '0;
  logic [NRD*DW-1:0] RD_Q;
  logic [DW-1:0]     R0_Q;
  logic              WB_PEND;
`ifdef SH_REGFILE_DBG_EN
  logic [NREG*DW-1:0] DBG_REGS;
`endif

  int errorCount = 0;
  int checkCount = 0;

  sh2_regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .EN(EN),
    .WA_ADDR(WA_ADDR), .WA_D(WA_D), .WAE(WAE),
    .WB_ADDR(WB_ADDR), .WB_D(WB_D), .WBE(WBE),
    .RD_ADDR(RD_ADDR), .RD_Q(RD_Q), .R0_Q(R0_Q), .WB_PEND(WB_PEND)
`ifdef SH_REGFILE_DBG_EN
    , .DBG_REGS(DBG_REGS)
`endif
  );

  always #10 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic en,
                               input logic wae, input logic [AW-1:0] waAddr, input logic [DW-1:0] waD,
                               input logic wbe, input logic [AW-1:0] wbAddr, input logic [DW-1:0] wbD);
    CE = ce; EN = en;
    WAE = wae; WA_ADDR = waAddr; WA_D = waD;
    WBE = wbe; WB_ADDR = wbAddr; WB_D = wbD;
    #0.1;
  endtask

  task automatic readCheck(input string tag, input int port, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    RD_ADDR[port*AW +: AW] = addr;
    #0.1;
    checkOutput(tag, RD_Q[port*DW +: DW], expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    #3;
    checkOutput("reset_r0", R0_Q, 32'h0);
    checkOutput("reset_pend", {31'b0, WB_PEND}, 32'h0);
    readCheck("reset_rd3", 0, 5'd3, 32'h0);
    tick();
    RST = 1'b0;
    tick();

    // Port A immediate write, not forwarded before its edge
    applyStimulus(1, 1, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    readCheck("a_no_forward", 0, 5'd3, 32'h0);
    tick();
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    readCheck("a_write_p0", 0, 5'd3, 32'hDEADBEEF);
    readCheck("a_write_p1_dup", 1, 5'd3, 32'hDEADBEEF);

    // Port B deferred write with forwarding while pending
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 1, 5'd5, 32'h12345678);
    tick();
    applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("b_pend_high", {31'b0, WB_PEND}, 32'h1);
    readCheck("b_forward_p0", 0, 5'd5, 32'h12345678);
    readCheck("b_forward_p2", 2, 5'd5, 32'h12345678);
    tick();
    checkOutput("b_pend_low", {31'b0, WB_PEND}, 32'h0);
    readCheck("b_committed", 0, 5'd5, 32'h12345678);

    // Same-edge collision on address 0: B wins
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 1, 5'd0, 32'hAAAA0000);
    tick();
    checkOutput("r0_not_yet", R0_Q, 32'h0);
    readCheck("r0_forward", 0, 5'd0, 32'hAAAA0000);
    applyStimulus(1, 1, 1, 5'd0, 32'h5555FFFF, 0, 5'd0, 32'h0);
    tick();
    checkOutput("collide_r0q", R0_Q, 32'hAAAA0000);
    readCheck("collide_rd0", 0, 5'd0, 32'hAAAA0000);
    checkOutput("collide_pend", {31'b0, WB_PEND}, 32'h0);

    // Different addresses commit on the same edge
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 1, 5'd1, 32'h00000011);
    tick();
    applyStimulus(1, 1, 1, 5'd2, 32'h00000022, 0, 5'd0, 32'h0);
    tick();
    readCheck("dual_b_addr1", 0, 5'd1, 32'h00000011);
    readCheck("dual_a_addr2", 1, 5'd2, 32'h00000022);
    checkOutput("dual_r0_kept", R0_Q, 32'hAAAA0000);

    // EN low blocks port A
    applyStimulus(1, 0, 1, 5'd6, 32'h00000066, 0, 5'd0, 32'h0);
    tick();
    readCheck("en_low_a", 0, 5'd6, 32'h0);

    // Latched B to PR dropped when EN low at its commit edge
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 1, 5'd16, 32'h0000CAFE);
    tick();
    checkOutput("pr_pend_high", {31'b0, WB_PEND}, 32'h1);
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    readCheck("pr_forward", 3, 5'd16, 32'h0000CAFE);
    tick();
    checkOutput("pr_pend_low", {31'b0, WB_PEND}, 32'h0);
    readCheck("pr_dropped", 3, 5'd16, 32'h0);
    applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();
    readCheck("pr_no_late_commit", 3, 5'd16, 32'h0);

    // Back-to-back B captures with CE held high
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 1, 5'd8, 32'h00000088);
    tick();
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 1, 5'd9, 32'h00000099);
    tick();
    checkOutput("b2b_pend", {31'b0, WB_PEND}, 32'h1);
    readCheck("b2b_addr8", 0, 5'd8, 32'h00000088);
    readCheck("b2b_addr9_fwd", 1, 5'd9, 32'h00000099);
    applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();
    checkOutput("b2b_pend_low", {31'b0, WB_PEND}, 32'h0);
    readCheck("b2b_addr9", 1, 5'd9, 32'h00000099);

    // Reset mid-operation discards pending B
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 1, 5'd7, 32'h00000001);
    tick();
    checkOutput("rst_pend_before", {31'b0, WB_PEND}, 32'h1);
    RST = 1'b1;
    #1;
    checkOutput("rst_pend_cleared", {31'b0, WB_PEND}, 32'h0);
    checkOutput("rst_r0_cleared", R0_Q, 32'h0);
    readCheck("rst_rd3_cleared", 0, 5'd3, 32'h0);
    applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    RST = 1'b0;
    tick();
    readCheck("rst_addr7", 0, 5'd7, 32'h0);
    checkOutput("rst_pend_after", {31'b0, WB_PEND}, 32'h0);

    // Out-of-range address 20 on all ports
    applyStimulus(1, 1, 1, 5'd20, 32'hBAD0BAD0, 1, 5'd20, 32'h5EED5EED);
    tick();
    applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("oor_pend", {31'b0, WB_PEND}, 32'h1);
    for (int p = 0; p < NRD; p++) readCheck($sformatf("oor_fwd_p%0d", p), p, 5'd20, 32'h0);
    tick();
    for (int p = 0; p < NRD; p++) readCheck($sformatf("oor_rd_p%0d", p), p, 5'd20, 32'h0);
    for (int r = 0; r < NREG; r++) readCheck($sformatf("oor_reg%0d", r), r % NRD, AW'(r), 32'h0);
    checkOutput("oor_r0", R0_Q, 32'h0);
`ifdef SH_REGFILE_DBG_EN
    for (int r = 0; r < NREG; r++) checkOutput($sformatf("oor_dbg%0d", r), DBG_REGS[r*DW +: DW], 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
